// File: rtl/dff_pipe_bank.sv
// dff_pipe_bank
//   WIDTH-bit, DEPTH-stage D-register delay line with per-stage valid
//   tracking, clock enable, flush, a selectable tap and an occupancy count.
//   Stage 0 is the input side; q is the data of stage DEPTH-1.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (highest priority)
//   en         advance enable; the line shifts only when 1
//   flush      clears valids (en=0) or keeps only the incoming valid (en=1)
//   d          input data
//   d_valid    qualifies d
//   tap_sel    stage index driving tap_q
//   q          data of the last stage
//   q_n        registered bitwise complement of q
//   q_valid    valid bit of the last stage
//   tap_q      data of stage tap_sel, 0 when tap_sel is out of range
//   occupancy  number of stages holding a valid sample
module dff_pipe_bank #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int             TAP_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] data_nxt [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [OCC_W-1:0] occ_nxt;
    logic [WIDTH-1:0] q_n_r;
    logic [OCC_W-1:0] occ_r;

    // Next-state of the line. Data moves whenever en is high, valid or not,
    // so bubbles keep carrying whatever data was in their slot.
    always_comb begin
        data_nxt = data;
        vld_nxt  = vld;
        if (en) begin
            data_nxt[0] = d;
            vld_nxt[0]  = d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                data_nxt[i] = data[i-1];
                // A flush during a shift keeps only the sample entering now.
                vld_nxt[i]  = flush ? 1'b0 : vld[i-1];
            end
        end else if (flush) begin
            vld_nxt = '0;
        end
    end

    // Occupancy is counted from the next-state valids so the registered
    // count lines up with the valid bits it describes.
    always_comb begin
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OCC_W'(vld_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RST_VAL;
            end
            vld   <= '0;
            q_n_r <= ~RST_VAL;
            occ_r <= '0;
        end else begin
            data  <= data_nxt;
            vld   <= vld_nxt;
            // Complement is its own flop fed from the next-state of the last
            // stage, so it switches on the same edge as q with no path from d.
            q_n_r <= ~data_nxt[DEPTH-1];
            occ_r <= occ_nxt;
        end
    end

    // Compare against each legal index rather than indexing directly, so an
    // out-of-range select (non power-of-two DEPTH) falls through to zero.
    always_comb begin
        tap_q = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_q = data[i];
            end
        end
    end

    assign q         = data[DEPTH-1];
    assign q_n       = q_n_r;
    assign q_valid   = vld[DEPTH-1];
    assign occupancy = occ_r;

endmodule

// File: tb/tb_dff_pipe_bank.sv
module tb_dff_pipe_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       flush = 1'b0;
    logic [7:0] d = 8'h00;
    logic       d_valid = 1'b0;
    logic [1:0] tap_sel = 2'd0;
    logic [7:0] q;
    logic [7:0] q_n;
    logic       q_valid;
    logic [7:0] tap_q;
    logic [2:0] occupancy;

    int checks = 0;
    int failures = 0;

    // Reference: the line as a queue of (data, valid), index 0 = input side.
    logic [7:0] md[$];
    bit         mv[$];

    dff_pipe_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .tap_sel(tap_sel), .q(q), .q_n(q_n), .q_valid(q_valid), .tap_q(tap_q),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    function automatic int m_occ();
        int n = 0;
        foreach (mv[i]) n += int'(mv[i]);
        return n;
    endfunction

    task automatic model_step(input bit r, input bit e, input bit f,
                              input logic [7:0] dd, input bit dv);
        logic [7:0] td;
        bit         tv;
        if (r) begin
            foreach (md[i]) begin md[i] = 8'h00; mv[i] = 1'b0; end
        end else if (e) begin
            md.push_front(dd);
            mv.push_front(dv);
            td = md.pop_back();
            tv = mv.pop_back();
            if (f) for (int i = 1; i < DEPTH; i++) mv[i] = 1'b0;
        end else if (f) begin
            foreach (mv[i]) mv[i] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, take the edge, advance the model, settle.
    task automatic cycle(input bit r, input bit e, input bit f,
                         input logic [7:0] dd, input bit dv);
        rst = r; en = e; flush = f; d = dd; d_valid = dv;
        @(posedge clk);
        model_step(r, e, f, dd, dv);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
        checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
        checks++; if (q_n !== 8'hFF) begin failures++; $display("FAIL reset_q_n got=%h exp=ff", q_n); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL reset_q_valid got=%b exp=0", q_valid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_streaming();
        logic [7:0] din   [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00, 8'h00};
        logic [7:0] exp_q [8] = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int         exp_o [8] = '{1, 2, 3, 4, 4, 4, 4, 4};
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 1'b0, din[k], 1'b1);
            checks++; if (q !== exp_q[k]) begin failures++; $display("FAIL stream_q edge=%0d got=%h exp=%h", k + 1, q, exp_q[k]); end
            checks++; if (q_n !== ~exp_q[k]) begin failures++; $display("FAIL stream_q_n edge=%0d got=%h exp=%h", k + 1, q_n, ~exp_q[k]); end
            checks++; if (q_valid !== (k >= 3)) begin failures++; $display("FAIL stream_q_valid edge=%0d got=%b exp=%b", k + 1, q_valid, k >= 3); end
            checks++; if (int'(occupancy) != exp_o[k]) begin failures++; $display("FAIL stream_occ edge=%0d got=%0d exp=%0d", k + 1, occupancy, exp_o[k]); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] hq;
        bit         hv;
        int         ho;
        tap_sel = 2'd1;
        cycle(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1);
        hq = md[DEPTH-1]; hv = mv[DEPTH-1]; ho = m_occ();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, 1'b0, (k % 2 == 0) ? 8'hFF : 8'h00, 1'($urandom));
            checks++; if (q !== hq) begin failures++; $display("FAIL stall_q cyc=%0d got=%h exp=%h", k, q, hq); end
            checks++; if (q_valid !== hv) begin failures++; $display("FAIL stall_q_valid cyc=%0d got=%b exp=%b", k, q_valid, hv); end
            checks++; if (int'(occupancy) != ho) begin failures++; $display("FAIL stall_occ cyc=%0d got=%0d exp=%0d", k, occupancy, ho); end
            checks++; if (tap_q !== 8'hA5) begin failures++; $display("FAIL stall_tap1 cyc=%0d got=%h exp=a5", k, tap_q); end
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checks++; if (q !== 8'hA5) begin failures++; $display("FAIL stall_resume_q got=%h exp=a5", q); end
        checks++; if (q_n !== 8'h5A) begin failures++; $display("FAIL stall_resume_q_n got=%h exp=5a", q_n); end
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL stall_resume_q_valid got=%b exp=1", q_valid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b1);
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL flush_fill_occ got=%0d exp=4", occupancy); end
        tap_sel = 2'd0;
        cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL flush_occ got=%0d exp=1", occupancy); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL flush_q_valid got=%b exp=0", q_valid); end
        checks++; if (tap_q !== 8'h77) begin failures++; $display("FAIL flush_tap0 got=%h exp=77", tap_q); end
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom), 1'b0);
        checks++; if (q !== 8'h77) begin failures++; $display("FAIL flush_exit_q got=%h exp=77", q); end
        checks++; if (q_n !== 8'h88) begin failures++; $display("FAIL flush_exit_q_n got=%h exp=88", q_n); end
        checks++; if (q_valid !== 1'b1) begin failures++; $display("FAIL flush_exit_q_valid got=%b exp=1", q_valid); end
        checks++; if (occupancy !== 3'd1) begin failures++; $display("FAIL flush_exit_occ got=%0d exp=1", occupancy); end
        // Flush while stalled: valids cleared, data kept.
        cycle(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1);
        checks++; if (q !== 8'h77) begin failures++; $display("FAIL flush_hold_q got=%h exp=77", q); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL flush_hold_q_valid got=%b exp=0", q_valid); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_hold_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_bubbles();
        logic [7:0] exp_q  [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        bit         exp_v  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8'(k + 1), (k % 2) == 0);
        for (int k = 0; k < 4; k++) begin
            checks++; if (q !== exp_q[k]) begin failures++; $display("FAIL bubble_q idx=%0d got=%h exp=%h", k, q, exp_q[k]); end
            checks++; if (q_valid !== exp_v[k]) begin failures++; $display("FAIL bubble_q_valid idx=%0d got=%b exp=%b", k, q_valid, exp_v[k]); end
            checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL bubble_occ idx=%0d got=%0d exp=2", k, occupancy); end
            if (k < 3) cycle(1'b0, 1'b1, 1'b0, 8'(k + 5), (k % 2) == 0);
        end
    endtask

    task automatic test_tap_reset();
        logic [7:0] exp_t [4] = '{8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int k = 0; k < 4; k++) cycle(1'b0, 1'b1, 1'b0, 8'hC0 + 8'(k), 1'b1);
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s); #1;
            checks++; if (tap_q !== exp_t[s]) begin failures++; $display("FAIL tap_sweep sel=%0d got=%h exp=%h", s, tap_q, exp_t[s]); end
        end
        cycle(1'b1, 1'b1, 1'b0, 8'hEE, 1'b1);
        for (int s = 0; s < 4; s++) begin
            tap_sel = 2'(s); #1;
            checks++; if (tap_q !== 8'h00) begin failures++; $display("FAIL tap_after_rst sel=%0d got=%h exp=00", s, tap_q); end
        end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL tap_after_rst_occ got=%0d exp=0", occupancy); end
        checks++; if (q_n !== 8'hFF) begin failures++; $display("FAIL tap_after_rst_q_n got=%h exp=ff", q_n); end
    endtask

    task automatic test_random();
        int sel;
        for (int k = 0; k < 400; k++) begin
            tap_sel = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 7) == 0, 8'($urandom), 1'($urandom));
            sel = int'(tap_sel);
            checks++; if (q !== md[DEPTH-1]) begin failures++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", k, q, md[DEPTH-1]); end
            checks++; if (q_n !== ~md[DEPTH-1]) begin failures++; $display("FAIL rand_q_n cyc=%0d got=%h exp=%h", k, q_n, ~md[DEPTH-1]); end
            checks++; if (q_valid !== mv[DEPTH-1]) begin failures++; $display("FAIL rand_q_valid cyc=%0d got=%b exp=%b", k, q_valid, mv[DEPTH-1]); end
            checks++; if (int'(occupancy) != m_occ()) begin failures++; $display("FAIL rand_occ cyc=%0d got=%0d exp=%0d", k, occupancy, m_occ()); end
            checks++; if (tap_q !== md[sel]) begin failures++; $display("FAIL rand_tap cyc=%0d sel=%0d got=%h exp=%h", k, sel, tap_q, md[sel]); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin md.push_back(8'h00); mv.push_back(1'b0); end
        #1;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_bubbles();
        test_tap_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipe_bank.md
Name: dff_pipe_bank

Overview:
- Parametrised successor to the single-bit synchronous D flip-flop: a WIDTH-bit, DEPTH-stage D-register delay line.
- Provides a registered true output and a complementary output, per-stage valid tracking, clock enable, flush, a selectable tap read and an occupancy count.
- Used as the general retiming/delay element in the flip-flop test area and as an aligned-delay primitive for datapaths.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of register stages (>=1)
- RST_VAL, 0, reset value loaded into every data stage (WIDTH bits)

Ports:
- clk  input  1  single clock, all state updates on its rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  advance enable; pipeline shifts only when 1
- flush  input  1  synchronous clear of all valid bits
- d  input  WIDTH  input data
- d_valid  input  1  qualifies d
- tap_sel  input  max(1,clog2(DEPTH))  stage index for tap_q
- q  output  WIDTH  data of stage DEPTH-1 (registered)
- q_n  output  WIDTH  bitwise complement of q (registered)
- q_valid  output  1  valid bit of stage DEPTH-1
- tap_q  output  WIDTH  data of stage tap_sel (combinational mux of registers)
- occupancy  output  clog2(DEPTH+1)  number of stages with valid=1 (registered)

Behaviour:
- Clock and reset: one clock is clk. Reset is rst, synchronous and active-high, sampled only on the rising edge of clk.
- State: data[0..DEPTH-1] (WIDTH bits each) and vld[0..DEPTH-1]. Stage 0 is the input side; q = data[DEPTH-1].
- Reset (rst=1 at the edge) has priority over everything:
  - every data[i] <= RST_VAL, every vld[i] <= 0
  - q = RST_VAL, q_n = ~RST_VAL, q_valid = 0, occupancy = 0
- Shift (en=1, rst=0):
  - data[0] <= d and vld[0] <= d_valid
  - data[i] <= data[i-1] and vld[i] <= vld[i-1] for i >= 1
  - Data shifts regardless of valid, so bubbles carry their data.
- Hold (en=0, flush=0): all state holds.
- Latency: a sample presented with en=1 appears on q after exactly DEPTH enabled edges. With en held at 1, that is DEPTH clk cycles.
- q_n always equals ~q, including in the reset state. It is a registered complement, updated on the same edge as q, with no combinational glitch path from d.
- Flush (flush=1, rst=0):
  - With en=0: all vld <= 0; data unchanged.
  - With en=1: data shifts normally; vld[0] <= d_valid; vld[i>=1] <= 0. The new sample survives and older ones are discarded.
- occupancy: registered popcount of the next-state vld vector, so it always matches vld in the same cycle.
  - Range is 0..DEPTH.
  - A valid entering while a valid leaves the last stage leaves occupancy unchanged.
- tap_q = data[tap_sel]. If tap_sel >= DEPTH, tap_q = 0.
- DEPTH=1: a single stage; tap_sel is 1 bit and only value 0 is legal.
- Reset asserted mid-stream discards all in-flight data and valids on that edge. The first sample after deassertion needs the full DEPTH enabled edges to reach q.
- No X propagation: every register is reset. Outputs never show X after the first reset edge.

Test Plan (WIDTH=8, DEPTH=4, RST_VAL=8'h00):
- Reset: rst=1 for 2 cycles with random d/en -> q=8'h00, q_n=8'hFF, q_valid=0, occupancy=0.
- Streaming: en=1, d_valid=1, d=8'h11,8'h22,8'h33,8'h44,8'h55 on consecutive cycles -> q=8'h11 with q_n=8'hEE four edges after 8'h11 is applied, then 8'h22..8'h55 on following cycles; occupancy ramps 1,2,3,4 and stays 4.
- Stall: load 8'hA5 into stage 1, then en=0 for 5 cycles with d toggling -> all outputs frozen. Resume en=1 -> 8'hA5 reaches q two edges later.
- Flush with shift: pipe full of valids, then flush=1 with en=1, d=8'h77, d_valid=1 -> next cycle occupancy=1, q_valid=0, tap_sel=0 gives tap_q=8'h77; 8'h77 exits on q with q_valid=1 three edges later.
- Bubbles: d_valid pattern 1,0,1,0 with d=8'h01..8'h04 -> q_valid pattern 1,0,1,0 at the output; q still shows 8'h02 and 8'h04 during the invalid cycles; occupancy stays 2.
- Mid-stream reset and tap: fill with 8'hC0..8'hC3, sweep tap_sel 0..3 -> tap_q = 8'hC3,8'hC2,8'hC1,8'hC0. Assert rst=1 for 1 cycle -> next cycle all tap_q=8'h00, occupancy=0.
